// File: rtl/instr_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_boot_loader_pkg
//  Brief    : Shared FSM state encoding and checksum width for the boot loader
//  Revision : 1.0 - initial release
// ============================================================================
package instr_boot_loader_pkg;

  // Width of the stored image checksum (wraps modulo 2**CKSUM_W)
  localparam int CKSUM_W = 16;

  // Loader sequence: PRIME -> COPY -> CHECK -> {DONE | ERR}
  typedef enum logic [2:0] {
    ST_PRIME = 3'd0,
    ST_COPY  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage : instr_boot_loader_pkg
`default_nettype wire

// File: rtl/instr_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_boot_loader
//  Brief    : Copies LOAD_WORDS words from program flash into instruction
//             memory, verifies them against the trailing checksum word and
//             holds the processor in reset until the image is good.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_boot_loader
  import instr_boot_loader_pkg::*;
#(
  parameter int ROM_AW     = 10,
  parameter int IMEM_AW    = 9,
  parameter int DATA_W     = 16,
  parameter int LOAD_WORDS = 512
) (
  input  logic               clk_in,
  input  logic               rst_load,
  input  logic               rst_processor,
  output logic               rom_en,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_do,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               done,
  output logic               err,
  output logic               proc_rst
);

  // Counter is one bit wider than the flash address so it can hold
  // LOAD_WORDS+1 (the drain step) even when LOAD_WORDS = 2**ROM_AW - 1.
  localparam int                CNT_W  = ROM_AW + 1;
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(LOAD_WORDS);
  localparam logic [CNT_W-1:0]  c_ONE  = CNT_W'(1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CKSUM_W-1:0]   r_sum;
  logic                 r_rom_en;
  logic [ROM_AW-1:0]    r_rom_addr;
  logic                 r_imem_we;
  logic [IMEM_AW-1:0]   r_imem_addr;
  logic                 r_done;
  logic                 r_err;

  logic [CKSUM_W-1:0]   w_rom_cks;
  logic [CNT_W-1:0]     w_cnt_m1;

  assign w_rom_cks = rom_do[CKSUM_W-1:0];
  assign w_cnt_m1  = r_cnt - c_ONE;

  // Flash data arrives one cycle after the read, so write data is taken
  // straight from rom_do while the (registered) write strobe is high.
  assign imem_wdata = r_imem_we ? rom_do : '0;

  assign rom_en    = r_rom_en;
  assign rom_addr  = r_rom_addr;
  assign imem_we   = r_imem_we;
  assign imem_addr = r_imem_addr;
  assign done      = r_done;
  assign err       = r_err;
  assign proc_rst  = rst_processor | ~r_done;

  // Loader FSM: issues flash reads, writes returned words, accumulates the
  // sum of every written word and compares it with the checksum word.
  always_ff @(posedge clk_in) begin
    if (rst_load) begin
      r_state     <= ST_PRIME;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_rom_en    <= 1'b0;
      r_rom_addr  <= '0;
      r_imem_we   <= 1'b0;
      r_imem_addr <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Every word presented to instruction memory is also summed
      if (r_imem_we) begin
        r_sum <= r_sum + w_rom_cks;
      end

      case (r_state)
        ST_PRIME: begin
          r_rom_en   <= 1'b1;
          r_rom_addr <= '0;
          r_cnt      <= c_ONE;
          r_state    <= ST_COPY;
        end

        ST_COPY: begin
          if (r_cnt <= c_LAST) begin
            // Read word k while writing word k-1 (returned from the previous read);
            // k = LOAD_WORDS fetches the checksum word.
            r_rom_en    <= 1'b1;
            r_rom_addr  <= r_cnt[ROM_AW-1:0];
            r_imem_we   <= 1'b1;
            r_imem_addr <= IMEM_AW'(w_cnt_m1);
            r_cnt       <= r_cnt + c_ONE;
          end else begin
            // Last image word is being written/summed now; checksum word
            // is on rom_do during CHECK.
            r_rom_en  <= 1'b0;
            r_imem_we <= 1'b0;
            r_state   <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          r_rom_en  <= 1'b0;
          r_imem_we <= 1'b0;
          if (w_rom_cks == r_sum) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end
        end

        ST_DONE: begin
          r_rom_en  <= 1'b0;
          r_imem_we <= 1'b0;
          r_done    <= 1'b1;
          r_err     <= 1'b0;
        end

        ST_ERR: begin
          r_rom_en  <= 1'b0;
          r_imem_we <= 1'b0;
          r_done    <= 1'b0;
          r_err     <= 1'b1;
        end

        default: begin
          r_rom_en  <= 1'b0;
          r_imem_we <= 1'b0;
          r_state   <= ST_PRIME;
        end
      endcase
    end
  end

endmodule : instr_boot_loader
`default_nettype wire

// File: tb/tb_instr_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_boot_loader
//  Brief    : Directed self-checking bench for instr_boot_loader with a
//             4-word image and a behavioural synchronous flash.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_boot_loader;

  localparam int ROM_AW     = 10;
  localparam int IMEM_AW    = 9;
  localparam int DATA_W     = 16;
  localparam int LOAD_WORDS = 4;

  logic               clk_in = 1'b0;
  logic               rst_load = 1'b1;
  logic               rst_processor = 1'b0;
  logic               rom_en;
  logic [ROM_AW-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_do = '0;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [DATA_W-1:0]  imem_wdata;
  logic               done;
  logic               err;
  logic               proc_rst;

  logic [DATA_W-1:0]  rom [0:7];
  logic               rand_rom = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  instr_boot_loader #(
    .ROM_AW     (ROM_AW),
    .IMEM_AW    (IMEM_AW),
    .DATA_W     (DATA_W),
    .LOAD_WORDS (LOAD_WORDS)
  ) dut (
    .clk_in        (clk_in),
    .rst_load      (rst_load),
    .rst_processor (rst_processor),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_do        (rom_do),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .done          (done),
    .err           (err),
    .proc_rst      (proc_rst)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous flash: data valid one cycle after rom_en; can be made noisy
  always @(posedge clk_in) begin
    if (rand_rom)
      rom_do <= 16'($urandom);
    else if (rom_en)
      rom_do <= rom[rom_addr[2:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_load = 1'b1;
    step();
    rst_load = 1'b0;
  endtask

  // Cycle c counts edges after the reset edge. Writes appear on cycles 2..5
  // (addr c-2), done/err on cycle 7.
  task automatic run_load(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3,
                          input logic [15:0] cks, input bit exp_ok,
                          input string name);
    logic [15:0] img [0:3];
    img[0] = w0; img[1] = w1; img[2] = w2; img[3] = w3;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = cks;
    do_reset();
    check({name, "_rst_we"},   {31'd0, imem_we}, 32'd0);
    check({name, "_rst_done"}, {31'd0, done},    32'd0);
    check({name, "_rst_err"},  {31'd0, err},     32'd0);
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) begin
        check({name, "_prime_en"},   {31'd0, rom_en}, 32'd1);
        check({name, "_prime_addr"}, 32'(rom_addr),   32'd0);
      end
      if (c >= 2 && c <= 5) begin
        check($sformatf("%s_we_c%0d", name, c),    {31'd0, imem_we}, 32'd1);
        check($sformatf("%s_addr_c%0d", name, c),  32'(imem_addr),   32'(c - 2));
        check($sformatf("%s_data_c%0d", name, c),  32'(imem_wdata),  32'(img[c - 2]));
      end else begin
        check($sformatf("%s_nowe_c%0d", name, c),  {31'd0, imem_we}, 32'd0);
      end
      if (c == 6) begin
        check({name, "_early_done"}, {31'd0, done}, 32'd0);
        check({name, "_early_err"},  {31'd0, err},  32'd0);
      end
    end
    check({name, "_done"}, {31'd0, done}, {31'd0, exp_ok});
    check({name, "_err"},  {31'd0, err},  {31'd0, ~exp_ok});
    check({name, "_proc_rst"}, {31'd0, proc_rst}, {31'd0, rst_processor | ~exp_ok});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = '0;
    rst_load = 1'b1;
    step();
    step();
    // Reset state
    check("reset_rom_en",   {31'd0, rom_en},  32'd0);
    check("reset_rom_addr", 32'(rom_addr),    32'd0);
    check("reset_imem_we",  {31'd0, imem_we}, 32'd0);
    check("reset_addr",     32'(imem_addr),   32'd0);
    check("reset_wdata",    32'(imem_wdata),  32'd0);
    check("reset_proc_rst", {31'd0, proc_rst}, 32'd1);

    // 1: good checksum
    run_load(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA, 1'b1, "t1");

    // 2: bad checksum
    run_load(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAB, 1'b0, "t2");

    // 3: sum wraps modulo 2**16
    run_load(16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0001, 1'b1, "t3");

    // 4: abort right after the write to addr 1
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
    rom[4] = 16'hAAAA;
    do_reset();
    step(); step(); step();
    check("t4_pre_we",   {31'd0, imem_we}, 32'd1);
    check("t4_pre_addr", 32'(imem_addr),   32'd1);
    rst_load = 1'b1;
    step();
    check("t4_abort_we",   {31'd0, imem_we}, 32'd0);
    check("t4_abort_done", {31'd0, done},    32'd0);
    run_load(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA, 1'b1, "t4");

    // 5: external processor reset held through load
    rst_processor = 1'b1;
    run_load(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA, 1'b1, "t5");
    step();
    check("t5_hold_proc_rst", {31'd0, proc_rst}, 32'd1);
    rst_processor = 1'b0;
    #1;
    check("t5_release_proc_rst", {31'd0, proc_rst}, 32'd0);

    // 6: noisy flash after done
    rand_rom = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("t6_we_%0d", i),   {31'd0, imem_we}, 32'd0);
      check($sformatf("t6_done_%0d", i), {31'd0, done},    32'd1);
      check($sformatf("t6_err_%0d", i),  {31'd0, err},     32'd0);
    end
    rand_rom = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instr_boot_loader
`default_nettype wire
